// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button conditioning path: FSM encoding and
// 100 MHz cycle constants.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam int unsigned CYCLES_10MS = 32'd1_000_000;
  localparam int unsigned CYCLES_1S   = 32'd100_000_000;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; clears to 0 on reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronised input, debounced level, and one-cycle
// press / release / long-press strobes, all registered.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = CYCLES_10MS,
  parameter int unsigned LONG_CYCLES     = CYCLES_1S,
  parameter int unsigned CNT_W           = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_in_i,
  output logic btn_level_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_in_i),
    .q_o   (s)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RELEASED;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    // Hold timer runs through release-wait too; parking at LONG_CYCLES
    // (one past the firing value) blocks a repeat long-press.
    if (state_q == HELD || state_q == RELEASE_WAIT) begin
      if (hold_cnt_q == LONG_LAST) begin
        long_d     = 1'b1;
        hold_cnt_d = HOLD_SAT;
      end else if (hold_cnt_q != HOLD_SAT) begin
        hold_cnt_d = hold_cnt_q + CNT_ONE;
      end
    end

    unique case (state_q)
      RELEASED: begin
        if (s) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d  = RELEASED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = HELD;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          press_d    = 1'b1;
          level_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = RELEASED;
          db_cnt_d  = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign btn_level_o  = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;

endmodule
